// File: rtl/pistorm_pkg.sv
// Shared register map, status layout, request payload and issue FSM states.
package pistorm_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int unsigned STAT_BUSY_BIT = 15;
  localparam int unsigned STAT_OVF_BIT  = 14;
  localparam int unsigned STAT_CNT_LSB  = 11;

  localparam int unsigned HI_BYTE_BIT = 8;
  localparam int unsigned HI_RW_BIT   = 9;
  localparam int unsigned HI_FC_LSB   = 10;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [2:0]  fc;
  } txn_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/pistorm_sync_fifo.sv
// Small synchronous FIFO of bus requests; a push into a full FIFO is accepted only alongside a pop.
module pistorm_sync_fifo
  import pistorm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  txn_t                         i_data,
  output txn_t                         o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  txn_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rptr];
  assign o_count   = r_count;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pistorm_txn_queue.sv
// Pi register front end: decodes GPIO strobes, queues 68k requests, issues them one at a time.
module pistorm_txn_queue
  import pistorm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        PI_CLK,
  input  logic        RST_n,
  input  logic [1:0]  PI_A,
  input  logic        PI_RD,
  input  logic        PI_WR,
  input  logic [15:0] PI_D_IN,
  output logic [15:0] PI_D_OUT,
  output logic        PI_D_OE,
  output logic        PI_TXN_IN_PROGRESS,
  output logic        OP_VALID,
  input  logic        OP_READY,
  output logic [23:0] OP_ADDR,
  output logic [15:0] OP_WDATA,
  output logic        OP_RW,
  output logic        OP_UDS_n,
  output logic        OP_LDS_n,
  output logic [2:0]  OP_FC,
  input  logic        DONE,
  input  logic [15:0] DONE_RDATA
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam txn_t OP_RESET = '{addr: '0, wdata: '0, rw: 1'b1, uds_n: 1'b1, lds_n: 1'b1, fc: '0};

  logic             r_rd_s1, r_rd_s2;
  logic             r_wr_s1, r_wr_s2, r_wr_s3;
  logic [15:0]      r_wdata_hold, r_addr_lo_hold, r_rdata;
  logic             r_lo_pending, r_ovf, r_busy, r_op_valid, r_d_oe;
  logic [15:0]      r_d_out;
  txn_t             r_op;
  state_t           r_state, w_state_nxt;
  logic             w_wr_rise, w_commit, w_push, w_pop, w_overflow, w_busy, w_launch;
  logic             w_full, w_empty;
  logic [CNT_W-1:0] w_count;
  txn_t             w_entry, w_head;
  logic [15:0]      w_status;

  // Two-flop synchronizers plus one edge-detect register on the Pi strobes.
  always_ff @(posedge PI_CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_rd_s1 <= 1'b0;
      r_rd_s2 <= 1'b0;
      r_wr_s1 <= 1'b0;
      r_wr_s2 <= 1'b0;
      r_wr_s3 <= 1'b0;
    end else begin
      r_rd_s1 <= PI_RD;
      r_rd_s2 <= r_rd_s1;
      r_wr_s1 <= PI_WR;
      r_wr_s2 <= r_wr_s1;
      r_wr_s3 <= r_wr_s2;
    end
  end

  assign w_wr_rise  = r_wr_s2 & ~r_wr_s3;
  assign w_commit   = w_wr_rise & (PI_A == REG_ADDR_HI);
  assign w_pop      = (r_state == ST_ISSUE) & OP_READY;
  assign w_push     = w_commit & (~w_full | w_pop);
  assign w_overflow = w_commit & w_full & ~w_pop;
  assign w_busy     = r_lo_pending | (w_count != '0) | (r_state != ST_IDLE);

  // Assemble a request from the ADDR_HI write and the held DATA/ADDR_LO values.
  always_comb begin
    w_entry       = '0;
    w_entry.addr  = {PI_D_IN[7:0], r_addr_lo_hold};
    w_entry.wdata = r_wdata_hold;
    w_entry.rw    = PI_D_IN[HI_RW_BIT];
    w_entry.fc    = PI_D_IN[HI_FC_LSB +: 3];
    if (PI_D_IN[HI_BYTE_BIT]) begin
      w_entry.uds_n = r_addr_lo_hold[0];
      w_entry.lds_n = ~r_addr_lo_hold[0];
    end
  end

  // Pi register writes: holding registers, pending low half, sticky overflow.
  always_ff @(posedge PI_CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_wdata_hold   <= '0;
      r_addr_lo_hold <= '0;
      r_lo_pending   <= 1'b0;
      r_ovf          <= 1'b0;
    end else begin
      if (w_wr_rise) begin
        unique case (PI_A)
          REG_DATA:    r_wdata_hold <= PI_D_IN;
          REG_ADDR_LO: begin
            r_addr_lo_hold <= PI_D_IN;
            r_lo_pending   <= 1'b1;
          end
          REG_ADDR_HI: r_lo_pending <= 1'b0;
          REG_STATUS:  if (PI_D_IN[STAT_OVF_BIT]) r_ovf <= 1'b0;
          default:     ;
        endcase
      end
      if (w_overflow) r_ovf <= 1'b1;
    end
  end

  pistorm_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (PI_CLK),
    .rst_n   (RST_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Issue FSM state register.
  always_ff @(posedge PI_CLK or negedge RST_n) begin
    if (!RST_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Issue FSM next state: one outstanding request at a time.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (!w_empty) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (OP_READY) w_state_nxt = ST_WAIT;
      ST_WAIT:  if (DONE)     w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_launch = (r_state == ST_IDLE) && (w_state_nxt == ST_ISSUE);

  // Request outputs: latch the FIFO head on launch, hold it until accepted.
  always_ff @(posedge PI_CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_op       <= OP_RESET;
      r_op_valid <= 1'b0;
    end else if (w_launch) begin
      r_op       <= w_head;
      r_op_valid <= 1'b1;
    end else if (w_pop) begin
      r_op_valid <= 1'b0;
    end
  end

  // Read data capture on completion of a read cycle.
  always_ff @(posedge PI_CLK or negedge RST_n) begin
    if (!RST_n)                                        r_rdata <= '0;
    else if ((r_state == ST_WAIT) && DONE && r_op.rw)  r_rdata <= DONE_RDATA;
  end

  // Status word as seen by the Pi.
  always_comb begin
    w_status                       = '0;
    w_status[STAT_BUSY_BIT]        = w_busy;
    w_status[STAT_OVF_BIT]         = r_ovf;
    w_status[STAT_CNT_LSB +: 3]    = 3'(w_count);
  end

  // Pi read bus and busy flag, re-evaluated every cycle.
  always_ff @(posedge PI_CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_d_out <= '0;
      r_d_oe  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_busy  <= w_busy;
      r_d_out <= '0;
      r_d_oe  <= 1'b0;
      if (r_rd_s2 && (PI_A == REG_DATA)) begin
        r_d_out <= r_rdata;
        r_d_oe  <= 1'b1;
      end else if (r_rd_s2 && (PI_A == REG_STATUS)) begin
        r_d_out <= w_status;
        r_d_oe  <= 1'b1;
      end
    end
  end

  assign PI_D_OUT           = r_d_out;
  assign PI_D_OE            = r_d_oe;
  assign PI_TXN_IN_PROGRESS = r_busy;
  assign OP_VALID           = r_op_valid;
  assign OP_ADDR            = r_op.addr;
  assign OP_WDATA           = r_op.wdata;
  assign OP_RW              = r_op.rw;
  assign OP_UDS_n           = r_op.uds_n;
  assign OP_LDS_n           = r_op.lds_n;
  assign OP_FC              = r_op.fc;

endmodule

// File: tb/tb_pistorm_txn_queue.sv
// Bench for pistorm_txn_queue: Pi register model, bus-engine model and request scoreboard.
module tb_pistorm_txn_queue;
  import pistorm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  PI_A = 2'd0;
  logic        PI_RD = 1'b0;
  logic        PI_WR = 1'b0;
  logic [15:0] PI_D_IN = '0;
  logic [15:0] PI_D_OUT;
  logic        PI_D_OE;
  logic        PI_TXN_IN_PROGRESS;
  logic        OP_VALID;
  logic        OP_READY = 1'b0;
  logic [23:0] OP_ADDR;
  logic [15:0] OP_WDATA;
  logic        OP_RW, OP_UDS_n, OP_LDS_n;
  logic [2:0]  OP_FC;
  logic        DONE = 1'b0;
  logic [15:0] DONE_RDATA = '0;

  int   total = 0;
  int   bad = 0;
  txn_t sb[$];

  pistorm_txn_queue #(.DEPTH(4)) dut (
    .PI_CLK(clk), .RST_n(rst_n), .PI_A(PI_A), .PI_RD(PI_RD), .PI_WR(PI_WR),
    .PI_D_IN(PI_D_IN), .PI_D_OUT(PI_D_OUT), .PI_D_OE(PI_D_OE),
    .PI_TXN_IN_PROGRESS(PI_TXN_IN_PROGRESS), .OP_VALID(OP_VALID), .OP_READY(OP_READY),
    .OP_ADDR(OP_ADDR), .OP_WDATA(OP_WDATA), .OP_RW(OP_RW), .OP_UDS_n(OP_UDS_n),
    .OP_LDS_n(OP_LDS_n), .OP_FC(OP_FC), .DONE(DONE), .DONE_RDATA(DONE_RDATA)
  );

  always #5 clk = ~clk;

  function automatic txn_t mk_exp(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] wd);
    txn_t t;
    t.addr  = {hi[7:0], lo};
    t.wdata = wd;
    t.rw    = hi[9];
    t.fc    = hi[12:10];
    if (hi[8]) begin
      t.uds_n = lo[0];
      t.lds_n = ~lo[0];
    end else begin
      t.uds_n = 1'b0;
      t.lds_n = 1'b0;
    end
    return t;
  endfunction

  function automatic txn_t get_obs();
    txn_t t;
    t.addr = OP_ADDR; t.wdata = OP_WDATA; t.rw = OP_RW;
    t.uds_n = OP_UDS_n; t.lds_n = OP_LDS_n; t.fc = OP_FC;
    return t;
  endfunction

  task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    PI_A = a; PI_D_IN = d; PI_WR = 1'b1;
    repeat (4) @(negedge clk);
    PI_WR = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pi_read(input logic [1:0] a, output logic [15:0] d, output logic oe);
    @(negedge clk);
    PI_A = a; PI_RD = 1'b1;
    repeat (3) @(negedge clk);
    d = PI_D_OUT; oe = PI_D_OE;
    PI_RD = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic commit_txn(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] wd,
                            input bit expect_it);
    pi_write(REG_DATA, wd);
    pi_write(REG_ADDR_LO, lo);
    pi_write(REG_ADDR_HI, hi);
    if (expect_it) sb.push_back(mk_exp(lo, hi, wd));
  endtask

  task automatic pulse_done(input logic [15:0] rd);
    @(negedge clk);
    DONE = 1'b1; DONE_RDATA = rd;
    @(negedge clk);
    DONE = 1'b0;
  endtask

  // Bus engine: wait for a request, score it, accept it, optionally complete it.
  task automatic accept_one(input logic [15:0] rd, input bit do_done);
    txn_t obs, exp;
    int cyc = 0;
    while (OP_VALID !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (OP_VALID !== 1'b1) begin
      bad++;
      $display("FAIL op_valid_timeout: got %b want 1", OP_VALID);
      return;
    end
    obs = get_obs();
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_op: got %h want none", obs);
    end else begin
      exp = sb.pop_front();
      if (obs !== exp) begin
        bad++;
        $display("FAIL op_fields: got %h want %h", obs, exp);
      end
    end
    OP_READY = 1'b1;
    @(negedge clk);
    OP_READY = 1'b0;
    total++;
    if (OP_VALID !== 1'b0) begin
      bad++;
      $display("FAIL op_valid_after_accept: got %b want 0", OP_VALID);
    end
    if (do_done) pulse_done(rd);
  endtask

  task automatic test_reset();
    logic [15:0] d; logic oe;
    total++;
    if ({OP_VALID, OP_RW, OP_UDS_n, OP_LDS_n, OP_ADDR, OP_WDATA, OP_FC} !== {4'b0111, 24'h0, 16'h0, 3'h0}) begin
      bad++;
      $display("FAIL reset_op: got %b%b%b%b %h %h %h want 0111 000000 0000 0",
               OP_VALID, OP_RW, OP_UDS_n, OP_LDS_n, OP_ADDR, OP_WDATA, OP_FC);
    end
    total++;
    if ({PI_TXN_IN_PROGRESS, PI_D_OE, PI_D_OUT} !== 18'h0) begin
      bad++;
      $display("FAIL reset_pi: got %b %b %h want 0 0 0000", PI_TXN_IN_PROGRESS, PI_D_OE, PI_D_OUT);
    end
    pi_read(REG_STATUS, d, oe);
    total++;
    if ({oe, d} !== {1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL reset_status: got oe=%b %h want oe=1 0000", oe, d);
    end
  endtask

  task automatic test_word_write();
    int seen = 0;
    pi_write(REG_DATA, 16'hBEEF);
    pi_write(REG_ADDR_LO, 16'h1234);
    sb.push_back('{addr: 24'h121234, wdata: 16'hBEEF, rw: 1'b0, uds_n: 1'b0, lds_n: 1'b0, fc: 3'd0});
    @(negedge clk);
    PI_A = REG_ADDR_HI; PI_D_IN = 16'h0012; PI_WR = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (OP_VALID !== 1'b0) begin
      bad++;
      $display("FAIL commit_latency_early: got %b want 0", OP_VALID);
    end
    @(negedge clk);
    total++;
    if (OP_VALID !== 1'b1) begin
      bad++;
      $display("FAIL commit_latency: got %b want 1", OP_VALID);
    end
    total++;
    if (PI_TXN_IN_PROGRESS !== 1'b1) begin
      bad++;
      $display("FAIL busy_word: got %b want 1", PI_TXN_IN_PROGRESS);
    end
    PI_WR = 1'b0;
    repeat (3) @(negedge clk);
    accept_one(16'h5555, 1'b1);
    repeat (10) begin
      @(negedge clk);
      if (OP_VALID === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL single_handshake: got %0d extra valid cycles want 0", seen);
    end
  endtask

  task automatic test_byte_read();
    logic [15:0] d; logic oe;
    pi_write(REG_ADDR_LO, 16'h0001);
    pi_write(REG_ADDR_HI, 16'h0300);
    sb.push_back('{addr: 24'h000001, wdata: 16'hBEEF, rw: 1'b1, uds_n: 1'b1, lds_n: 1'b0, fc: 3'd0});
    accept_one(16'h00A5, 1'b1);
    pi_read(REG_DATA, d, oe);
    total++;
    if ({oe, d} !== {1'b1, 16'h00A5}) begin
      bad++;
      $display("FAIL byte_read_data: got oe=%b %h want oe=1 00a5", oe, d);
    end
    pi_read(REG_ADDR_LO, d, oe);
    total++;
    if ({oe, d} !== {1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL addr_lo_read: got oe=%b %h want oe=0 0000", oe, d);
    end
  endtask

  task automatic fill_four(input logic [15:0] base);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] hi;
      hi = 16'(i << 10) | 16'(8'h40 + i);
      if (i == 2) hi = hi | 16'h0100;
      commit_txn(base + 16'(i * 2), hi, 16'hA000 + 16'(i) + base, 1'b1);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d; logic oe;
    int seen = 0;
    fill_four(16'h1000);
    pi_read(REG_STATUS, d, oe);
    total++;
    if (d !== 16'hA000) begin
      bad++;
      $display("FAIL status_full: got %h want a000", d);
    end
    commit_txn(16'h7770, 16'h00EE, 16'h9999, 1'b0);
    pi_read(REG_STATUS, d, oe);
    total++;
    if (d !== 16'hE000) begin
      bad++;
      $display("FAIL status_ovf: got %h want e000", d);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (OP_VALID !== 1'b1 || get_obs() !== sb[0]) begin
        bad++;
        $display("FAIL op_stable: got v=%b %h want v=1 %h", OP_VALID, get_obs(), sb[0]);
      end
    end
    for (int k = 0; k < 4; k++) accept_one(16'h1111, 1'b1);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_left: got %0d want 0", sb.size());
    end
    repeat (20) begin
      @(negedge clk);
      if (OP_VALID === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL dropped_entry_issued: got %0d valid cycles want 0", seen);
    end
    pi_read(REG_STATUS, d, oe);
    total++;
    if (d !== 16'h4000) begin
      bad++;
      $display("FAIL status_after_drain: got %h want 4000", d);
    end
  endtask

  task automatic test_status_clear();
    logic [15:0] d; logic oe;
    pi_write(REG_STATUS, 16'h4000);
    pi_read(REG_STATUS, d, oe);
    total++;
    if (d !== 16'h0000) begin
      bad++;
      $display("FAIL ovf_clear: got %h want 0000", d);
    end
  endtask

  task automatic test_full_pop();
    logic [15:0] d; logic oe;
    txn_t exp;
    fill_four(16'h2000);
    pi_write(REG_DATA, 16'h5A5A);
    pi_write(REG_ADDR_LO, 16'h3004);
    total++;
    exp = sb.pop_front();
    if (OP_VALID !== 1'b1 || get_obs() !== exp) begin
      bad++;
      $display("FAIL full_pop_head: got v=%b %h want v=1 %h", OP_VALID, get_obs(), exp);
    end
    @(negedge clk);
    PI_A = REG_ADDR_HI; PI_D_IN = 16'h0455; PI_WR = 1'b1;
    repeat (2) @(negedge clk);
    OP_READY = 1'b1;
    @(negedge clk);
    OP_READY = 1'b0;
    sb.push_back(mk_exp(16'h3004, 16'h0455, 16'h5A5A));
    total++;
    if (OP_VALID !== 1'b0) begin
      bad++;
      $display("FAIL full_pop_valid: got %b want 0", OP_VALID);
    end
    repeat (2) @(negedge clk);
    PI_WR = 1'b0;
    repeat (3) @(negedge clk);
    pi_read(REG_STATUS, d, oe);
    total++;
    if (d !== 16'hA000) begin
      bad++;
      $display("FAIL full_pop_status: got %h want a000", d);
    end
    pulse_done(16'hDEAD);
    for (int k = 0; k < 4; k++) accept_one(16'hDEAD, 1'b1);
  endtask

  task automatic test_stray_done();
    logic [15:0] d; logic oe;
    repeat (3) @(negedge clk);
    pulse_done(16'h1234);
    pi_read(REG_DATA, d, oe);
    total++;
    if ({oe, d} !== {1'b1, 16'h00A5}) begin
      bad++;
      $display("FAIL stray_done_rdata: got oe=%b %h want oe=1 00a5", oe, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; logic oe;
    int cyc = 0;
    commit_txn(16'h0002, 16'h0200, 16'h0000, 1'b1);
    accept_one(16'h0000, 1'b0);
    @(negedge clk);
    total++;
    if (PI_TXN_IN_PROGRESS !== 1'b1) begin
      bad++;
      $display("FAIL busy_in_wait: got %b want 1", PI_TXN_IN_PROGRESS);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({OP_VALID, PI_TXN_IN_PROGRESS} !== 2'b00) begin
      bad++;
      $display("FAIL reset_in_wait: got %b%b want 00", OP_VALID, PI_TXN_IN_PROGRESS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    pi_read(REG_STATUS, d, oe);
    total++;
    if ({oe, d} !== {1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL status_after_reset: got oe=%b %h want oe=1 0000", oe, d);
    end
    commit_txn(16'h0010, 16'h0001, 16'h4321, 1'b0);
    while (OP_VALID !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (OP_VALID !== 1'b1) begin
      bad++;
      $display("FAIL issue_before_reset: got %b want 1", OP_VALID);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({OP_VALID, OP_RW, OP_ADDR} !== {2'b01, 24'h0}) begin
      bad++;
      $display("FAIL async_reset_issue: got v=%b rw=%b %h want v=0 rw=1 000000", OP_VALID, OP_RW, OP_ADDR);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_word_write();
    test_byte_read();
    test_overflow();
    test_status_clear();
    test_full_pop();
    test_stray_done();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
